// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered ALU between NUM_REQ requesters.
// Optional feature macro: ALU_ARB_DIVZERO_EN (divide-by-zero answered locally with an error).
module alu_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FUNC_WIDTH = 4
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [NUM_REQ-1:0]               REQ_VALID,
    output logic [NUM_REQ-1:0]               REQ_READY,
    input  logic [NUM_REQ*FUNC_WIDTH-1:0]    REQ_FUN,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    REQ_A,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    REQ_B,
    output logic [NUM_REQ-1:0]               RSP_VALID,
    input  logic [NUM_REQ-1:0]               RSP_READY,
    output logic [DATA_WIDTH-1:0]            RSP_DATA,
    output logic                             RSP_ERR,
    output logic                             ALU_EN,
    output logic [FUNC_WIDTH-1:0]            ALU_FUN,
    output logic [DATA_WIDTH-1:0]            ALU_A,
    output logic [DATA_WIDTH-1:0]            ALU_B,
    input  logic [DATA_WIDTH-1:0]            ALU_OUT,
    input  logic                             ALU_OUT_VALID,
    output logic                             BUSY
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        grant_q, grant_d;
    logic [FUNC_WIDTH-1:0]   aluFun_q, aluFun_d;
    logic [DATA_WIDTH-1:0]   aluA_q, aluA_d;
    logic [DATA_WIDTH-1:0]   aluB_q, aluB_d;
    logic [DATA_WIDTH-1:0]   rspData_q, rspData_d;

    logic [PTR_W-1:0]        winner;
    logic                    found;
    logic                    accept;
    logic                    divZero;
    logic [FUNC_WIDTH-1:0]   selFun;
    logic [DATA_WIDTH-1:0]   selA;
    logic [DATA_WIDTH-1:0]   selB;

`ifdef ALU_ARB_DIVZERO_EN
    localparam logic [FUNC_WIDTH-1:0] FUN_DIV = FUNC_WIDTH'(3);
    logic rspErr_q, rspErr_d;
`endif

    // Search starts one past the last grant, so a persistent requester waits at most NUM_REQ-1 grants.
    always_comb begin
        found  = 1'b0;
        winner = grant_q;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!found && REQ_VALID[(int'(grant_q) + off) % NUM_REQ]) begin
                found  = 1'b1;
                winner = PTR_W'((int'(grant_q) + off) % NUM_REQ);
            end
        end
    end

    assign selFun = REQ_FUN[winner*FUNC_WIDTH +: FUNC_WIDTH];
    assign selA   = REQ_A[winner*DATA_WIDTH +: DATA_WIDTH];
    assign selB   = REQ_B[winner*DATA_WIDTH +: DATA_WIDTH];
    assign accept = (state_q == IDLE) && found;

    always_comb begin
        REQ_READY = '0;
        if (accept) begin
            REQ_READY[winner] = 1'b1;
        end
    end

`ifdef ALU_ARB_DIVZERO_EN
    assign divZero = (selFun == FUN_DIV) && (selB == '0);
`else
    assign divZero = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        aluFun_d  = aluFun_q;
        aluA_d    = aluA_q;
        aluB_d    = aluB_q;
        rspData_d = rspData_q;
`ifdef ALU_ARB_DIVZERO_EN
        rspErr_d  = rspErr_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    grant_d = winner;
                    if (divZero) begin
                        // Never reaches the ALU; the operand registers keep the previous operation.
                        state_d   = RESP;
                        rspData_d = '1;
`ifdef ALU_ARB_DIVZERO_EN
                        rspErr_d  = 1'b1;
`endif
                    end else begin
                        state_d  = ISSUE;
                        aluFun_d = selFun;
                        aluA_d   = selA;
                        aluB_d   = selB;
`ifdef ALU_ARB_DIVZERO_EN
                        rspErr_d = 1'b0;
`endif
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (ALU_OUT_VALID) begin
                    state_d   = RESP;
                    rspData_d = ALU_OUT;
                end
            end
            RESP: begin
                if (RSP_READY[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            grant_q   <= PTR_W'(NUM_REQ - 1);
            aluFun_q  <= '0;
            aluA_q    <= '0;
            aluB_q    <= '0;
            rspData_q <= '0;
`ifdef ALU_ARB_DIVZERO_EN
            rspErr_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            aluFun_q  <= aluFun_d;
            aluA_q    <= aluA_d;
            aluB_q    <= aluB_d;
            rspData_q <= rspData_d;
`ifdef ALU_ARB_DIVZERO_EN
            rspErr_q  <= rspErr_d;
`endif
        end
    end

    always_comb begin
        RSP_VALID = '0;
        if (state_q == RESP) begin
            RSP_VALID[grant_q] = 1'b1;
        end
    end

    assign ALU_EN   = (state_q == ISSUE);
    assign ALU_FUN  = aluFun_q;
    assign ALU_A    = aluA_q;
    assign ALU_B    = aluB_q;
    assign RSP_DATA = rspData_q;
    assign BUSY     = (state_q != IDLE);

`ifdef ALU_ARB_DIVZERO_EN
    assign RSP_ERR = rspErr_q;
`else
    assign RSP_ERR = 1'b0;
`endif

endmodule
